fm_wm_address_gen: RTL and testbench

Parametrised address sequencer for the transformation stage (feature matrix × weight matrix). After a single `start` pulse it walks every weight column. For each column it issues one weight-memory read, then streams every feature-matrix row address, with an optional stall that freezes the sequence. Separate weight and feature address ports replace the earlier shared single-address generator, and a `start`/`done` handshake makes the block usable directly by the layer controller.

---
 rtl/fm_wm_addr_pkg.sv | 16 +
 rtl/fm_wm_addr_counter.sv | 36 +++
 rtl/fm_wm_address_gen.sv | 135 +++++++++++++
 tb/tb_fm_wm_address_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_wm_addr_pkg.sv
// Shared types and helpers for the feature x weight address sequencer.
package fm_wm_addr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWfetch,
    StFstream,
    StDone
  } fm_wm_state_t;

  // Index width that stays legal for a modulus of 1.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fm_wm_addr_counter.sv
// Index counter with a stride-accumulating address register; wraps to index 0 / BASE
// after MODULUS-1.
module fm_wm_addr_counter #(
  parameter int unsigned             IDX_W   = 1,
  parameter int unsigned             MODULUS = 1,
  parameter int unsigned             ADDR_W  = 13,
  parameter logic [ADDR_W-1:0]       BASE    = '0,
  parameter logic [ADDR_W-1:0]       STRIDE  = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  output logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr,
  output logic              at_last
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(MODULUS - 1);

  assign at_last = (idx == LastIdx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx  <= '0;
      addr <= '0;
    end else if (clear || (enable && at_last)) begin
      idx  <= '0;
      addr <= BASE;
    end else if (enable) begin
      idx  <= idx + IDX_W'(1);
      addr <= addr + STRIDE;
    end
  end

endmodule

// File: rtl/fm_wm_address_gen.sv
// Weight/feature address sequencer with start/done handshake and stall.
// Build option: FM_WM_ADDR_PREFETCH_EN overlaps the next weight read with the last feature row.
module fm_wm_address_gen
  import fm_wm_addr_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = 13,
  parameter int unsigned              FEATURE_ROWS  = 6,
  parameter int unsigned              WEIGHT_COLS   = 3,
  parameter logic [ADDRESS_WIDTH-1:0] FM_BASE       = ADDRESS_WIDTH'('h200),
  parameter logic [ADDRESS_WIDTH-1:0] WM_BASE       = ADDRESS_WIDTH'('h000),
  parameter logic [ADDRESS_WIDTH-1:0] FM_STRIDE     = ADDRESS_WIDTH'(1),
  parameter logic [ADDRESS_WIDTH-1:0] WM_STRIDE     = ADDRESS_WIDTH'(1),
  parameter int unsigned              ROW_W         = idx_width(FEATURE_ROWS),
  parameter int unsigned              COL_W         = idx_width(WEIGHT_COLS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stall,
  output logic [ADDRESS_WIDTH-1:0] wm_addr,
  output logic                     wm_valid,
  output logic [ADDRESS_WIDTH-1:0] fm_addr,
  output logic                     fm_valid,
  output logic [ROW_W-1:0]         row_idx,
  output logic [COL_W-1:0]         col_idx,
  output logic                     last_row,
  output logic                     busy,
  output logic                     done
);

  fm_wm_state_t state_q, state_d;
  logic busy_q, done_q;

  logic row_en, row_clr, row_last;
  logic col_en, col_clr, col_last;
  logic [ADDRESS_WIDTH-1:0] col_addr;

  assign row_clr = (state_q == StIdle);
  assign col_clr = (state_q == StIdle);
  assign row_en  = (state_q == StFstream) && !stall;
  assign col_en  = row_en && row_last && !col_last;

  fm_wm_addr_counter #(
    .IDX_W   (ROW_W),
    .MODULUS (FEATURE_ROWS),
    .ADDR_W  (ADDRESS_WIDTH),
    .BASE    (FM_BASE),
    .STRIDE  (FM_STRIDE)
  ) u_row_cnt (
    .clk     (clk),
    .reset   (reset),
    .enable  (row_en),
    .clear   (row_clr),
    .idx     (row_idx),
    .addr    (fm_addr),
    .at_last (row_last)
  );

  fm_wm_addr_counter #(
    .IDX_W   (COL_W),
    .MODULUS (WEIGHT_COLS),
    .ADDR_W  (ADDRESS_WIDTH),
    .BASE    (WM_BASE),
    .STRIDE  (WM_STRIDE)
  ) u_col_cnt (
    .clk     (clk),
    .reset   (reset),
    .enable  (col_en),
    .clear   (col_clr),
    .idx     (col_idx),
    .addr    (col_addr),
    .at_last (col_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StWfetch;
      end
      StWfetch: begin
        if (!stall) state_d = StFstream;
      end
      StFstream: begin
        if (!stall && row_last) begin
          if (col_last) begin
            state_d = StDone;
          end else begin
`ifdef FM_WM_ADDR_PREFETCH_EN
            state_d = StFstream;
`else
            state_d = StWfetch;
`endif
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // busy/done are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == StWfetch) || (state_d == StFstream);
      done_q  <= (state_d == StDone);
    end
  end

`ifdef FM_WM_ADDR_PREFETCH_EN
  logic pf_issue;
  // Next column's weight read rides along with the current column's last feature row.
  assign pf_issue = (state_q == StFstream) && row_last && !col_last;
  assign wm_addr  = pf_issue ? (col_addr + WM_STRIDE) : col_addr;
  assign wm_valid = ((state_q == StWfetch) || pf_issue) && !stall;
`else
  assign wm_addr  = col_addr;
  assign wm_valid = (state_q == StWfetch) && !stall;
`endif

  assign fm_valid = (state_q == StFstream) && !stall;
  assign last_row = fm_valid && row_last;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fm_wm_address_gen.sv
// Randomised/directed bench for fm_wm_address_gen against a step-list reference model.
module tb_fm_wm_address_gen;

  localparam int unsigned AW   = 13;
  localparam int unsigned ROWS = 6;
  localparam int unsigned COLS = 3;
  localparam logic [AW-1:0] FMB = 13'h200;
  localparam logic [AW-1:0] WMB = 13'h000;
  localparam logic [AW-1:0] FS  = 13'd1;
  localparam logic [AW-1:0] WS  = 13'd1;
`ifdef FM_WM_ADDR_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic [AW-1:0] wm_addr, fm_addr;
  logic wm_valid, fm_valid, last_row, busy, done;
  logic [2:0] row_idx;
  logic [1:0] col_idx;

  logic start2 = 1'b0;
  logic stall2 = 1'b0;
  logic [AW-1:0] w_wm_addr, w_fm_addr;
  logic w_wm_valid, w_fm_valid, w_last_row, w_busy, w_done;
  logic [1:0] w_row_idx;
  logic [0:0] w_col_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fm_wm_address_gen #(
    .ADDRESS_WIDTH (AW),
    .FEATURE_ROWS  (ROWS),
    .WEIGHT_COLS   (COLS),
    .FM_BASE       (FMB),
    .WM_BASE       (WMB),
    .FM_STRIDE     (FS),
    .WM_STRIDE     (WS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stall    (stall),
    .wm_addr  (wm_addr),
    .wm_valid (wm_valid),
    .fm_addr  (fm_addr),
    .fm_valid (fm_valid),
    .row_idx  (row_idx),
    .col_idx  (col_idx),
    .last_row (last_row),
    .busy     (busy),
    .done     (done)
  );

  fm_wm_address_gen #(
    .ADDRESS_WIDTH (AW),
    .FEATURE_ROWS  (3),
    .WEIGHT_COLS   (1),
    .FM_BASE       (13'h1FFE),
    .WM_BASE       (13'h000),
    .FM_STRIDE     (13'd2),
    .WM_STRIDE     (13'd1)
  ) dut_wrap (
    .clk      (clk),
    .reset    (reset),
    .start    (start2),
    .stall    (stall2),
    .wm_addr  (w_wm_addr),
    .wm_valid (w_wm_valid),
    .fm_addr  (w_fm_addr),
    .fm_valid (w_fm_valid),
    .row_idx  (w_row_idx),
    .col_idx  (w_col_idx),
    .last_row (w_last_row),
    .busy     (w_busy),
    .done     (w_done)
  );

  typedef struct {
    bit          wv;
    bit          fv;
    bit          last;
    logic [AW-1:0] wa;
    logic [AW-1:0] fa;
    int unsigned row;
    int unsigned col;
  } step_t;

  step_t steps[$];

  function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] base,
                                            input logic [AW-1:0] stride,
                                            input int unsigned n);
    return AW'(32'(base) + 32'(stride) * n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One entry per non-stalled busy cycle: a weight fetch, then each feature row, per column.
  task automatic build_steps();
    step_t s;
    bit pf_here;
    steps.delete();
    for (int unsigned c = 0; c < COLS; c++) begin
      if (!PF || c == 0) begin
        s.wv = 1'b1; s.fv = 1'b0; s.last = 1'b0;
        s.wa = addr_of(WMB, WS, c); s.fa = FMB; s.row = 0; s.col = c;
        steps.push_back(s);
      end
      for (int unsigned r = 0; r < ROWS; r++) begin
        pf_here = PF && (r == ROWS - 1) && (c < COLS - 1);
        s.wv = pf_here; s.fv = 1'b1; s.last = (r == ROWS - 1);
        s.wa = addr_of(WMB, WS, pf_here ? c + 1 : c);
        s.fa = addr_of(FMB, FS, r); s.row = r; s.col = c;
        steps.push_back(s);
      end
    end
  endtask

  task automatic chk_step(input string p, input step_t s);
    chk({p, "_wm_valid"}, 32'(wm_valid), 32'(s.wv));
    chk({p, "_fm_valid"}, 32'(fm_valid), 32'(s.fv));
    chk({p, "_last_row"}, 32'(last_row), 32'(s.last));
    chk({p, "_wm_addr"}, 32'(wm_addr), 32'(s.wa));
    chk({p, "_fm_addr"}, 32'(fm_addr), 32'(s.fa));
    chk({p, "_row_idx"}, 32'(row_idx), s.row);
    chk({p, "_col_idx"}, 32'(col_idx), s.col);
    chk({p, "_busy"}, 32'(busy), 32'd1);
    chk({p, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic chk_stalled(input string p, input step_t s);
    chk({p, "_st_wm_valid"}, 32'(wm_valid), 32'd0);
    chk({p, "_st_fm_valid"}, 32'(fm_valid), 32'd0);
    chk({p, "_st_last_row"}, 32'(last_row), 32'd0);
    chk({p, "_st_fm_addr"}, 32'(fm_addr), 32'(s.fa));
    chk({p, "_st_row_idx"}, 32'(row_idx), s.row);
    chk({p, "_st_col_idx"}, 32'(col_idx), s.col);
    chk({p, "_st_busy"}, 32'(busy), 32'd1);
    chk({p, "_st_done"}, 32'(done), 32'd0);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_wm_addr"}, 32'(wm_addr), 32'd0);
    chk({p, "_fm_addr"}, 32'(fm_addr), 32'd0);
    chk({p, "_valids"}, {30'd0, wm_valid, fm_valid}, 32'd0);
    chk({p, "_idx"}, {27'd0, row_idx, col_idx}, 32'd0);
    chk({p, "_flags"}, {29'd0, last_row, busy, done}, 32'd0);
    chk({p, "_w_addrs"}, {6'd0, w_wm_addr, w_fm_addr}, 32'd0);
    chk({p, "_w_flags"}, {27'd0, w_wm_valid, w_fm_valid, w_last_row, w_busy, w_done}, 32'd0);
  endtask

  // stall_mode: 0 none, 1 cycles 4-5, 2 random. abort_at: cycle to assert reset (0 = never).
  task automatic run_pass(input int stall_mode, input bit extra_start, input int abort_at);
    int unsigned idx;
    int cyc;
    string p;
    build_steps();
    @(negedge clk);
    start = 1'b1;
    stall = (stall_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valids", {30'd0, wm_valid, fm_valid}, 32'd0);
    idx = 0;
    cyc = 0;
    while (idx < steps.size()) begin
      @(negedge clk);
      cyc++;
      start = extra_start && (cyc == 5);
      case (stall_mode)
        1:       stall = (cyc == 4) || (cyc == 5);
        2:       stall = ($urandom_range(0, 3) == 0);
        default: stall = 1'b0;
      endcase
      p = $sformatf("m%0d_c%0d", stall_mode, cyc);
      if (abort_at != 0 && cyc == abort_at) begin
        reset = 1'b1;
        #1;
        chk_zero({p, "_abort"});
        @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_after_done", 32'(done), 32'd0);
        chk("abort_after_busy", 32'(busy), 32'd0);
        return;
      end
      #1;
      if (cyc > 1000) begin
        chk("pass_timeout", 32'(cyc), 32'd0);
        return;
      end
      if (stall) begin
        chk_stalled(p, steps[idx]);
      end else begin
        chk_step(p, steps[idx]);
        idx++;
      end
    end
    @(negedge clk);
    cyc++;
    start = extra_start;
    stall = (stall_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    chk($sformatf("m%0d_done_c%0d", stall_mode, cyc), 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_valids", {29'd0, wm_valid, fm_valid, last_row}, 32'd0);
    start = 1'b0;
    stall = 1'b0;
  endtask

  task automatic wrap_test();
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    #1;
    chk("wrap_wm_valid", 32'(w_wm_valid), 32'd1);
    chk("wrap_wm_addr", 32'(w_wm_addr), 32'd0);
    for (int unsigned r = 0; r < 3; r++) begin
      @(negedge clk);
      #1;
      chk($sformatf("wrap_fm_addr_r%0d", r), 32'(w_fm_addr), 32'(addr_of(13'h1FFE, 13'd2, r)));
      chk($sformatf("wrap_fm_valid_r%0d", r), 32'(w_fm_valid), 32'd1);
      chk($sformatf("wrap_last_r%0d", r), 32'(w_last_row), 32'(r == 2));
      chk($sformatf("wrap_row_r%0d", r), 32'(w_row_idx), r);
    end
    @(negedge clk);
    #1;
    chk("wrap_done", 32'(w_done), 32'd1);
  endtask

  initial begin
    #2;
    reset = 1'b1;
    #1;
    chk_zero("por");
    repeat (2) @(negedge clk);
    chk_zero("rst_held");
    reset = 1'b0;
    run_pass(0, 1'b0, 0);
    run_pass(1, 1'b0, 0);
    run_pass(0, 1'b0, 10);
    run_pass(0, 1'b1, 0);
    run_pass(0, 1'b0, 0);
    for (int i = 0; i < 3; i++) run_pass(2, 1'b0, 0);
    wrap_test();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
